mem_lane_ctrl: RTL and testbench

- Load/store front-end sitting directly upstream of the four byte-wide data-memory banks; each bank has a 10-bit address, 8-bit d/q, we, sel and combinational read.
- Accepts one CPU memory request at a time over a valid/ready handshake.
- Splits stores into per-byte lane writes with lane selects; merges and sign/zero-extends loads.
- Flags misaligned, illegal-size and out-of-range accesses.

---
 rtl/mem_lane_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_lane_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_ctrl.sv
// Load/store front-end for four byte-wide data-memory banks.
// Each request runs IDLE -> ACCESS -> RESP. Stores are split into lane writes; loads are merged and extended.
module mem_lane_ctrl #(
    parameter int BANK_AW     = 10,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [BANK_AW-1:0] bank_addr,
    output logic [31:0]        bank_d,
    output logic               bank_we,
    output logic [3:0]         bank_sel,
    input  logic [31:0]        bank_q
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        req_we_q, req_uns_q;
    logic [1:0]  req_size_q;
    logic [31:0] req_addr_q, req_wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q;
    logic        accept, acc_err, range_err;
    logic [3:0]  lane_mask;
    logic [7:0]  load_b;
    logic [15:0] load_h;
    logic [31:0] load_ext;

    assign accept = req_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_uns_q   <= 1'b0;
            req_size_q  <= 2'b00;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_we_q    <= req_we;
                req_uns_q   <= req_unsigned;
                req_size_q  <= req_size;
                req_addr_q  <= req_addr;
                req_wdata_q <= req_wdata;
            end
            if (state_q == ACCESS) begin
                rdata_q <= rdata_d;
                err_q   <= acc_err;
            end
        end
    end

    // Any address bit above the bank space is out of range.
    if (CHECK_RANGE && (BANK_AW + 2 < 32)) begin : g_range
        assign range_err = |req_addr_q[31:BANK_AW+2];
    end else begin : g_no_range
        assign range_err = 1'b0;
    end

    always_comb begin
        acc_err   = 1'b1;
        lane_mask = 4'b0000;
        unique case (req_size_q)
            2'b00: begin
                acc_err   = range_err;
                lane_mask = 4'b0001 << req_addr_q[1:0];
            end
            2'b01: begin
                acc_err   = range_err | req_addr_q[0];
                lane_mask = req_addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                acc_err   = range_err | (|req_addr_q[1:0]);
                lane_mask = 4'b1111;
            end
            default: begin
                acc_err   = 1'b1;
                lane_mask = 4'b0000;
            end
        endcase
    end

    always_comb begin
        unique case (req_addr_q[1:0])
            2'd0:    load_b = bank_q[7:0];
            2'd1:    load_b = bank_q[15:8];
            2'd2:    load_b = bank_q[23:16];
            default: load_b = bank_q[31:24];
        endcase
        load_h = req_addr_q[1] ? bank_q[31:16] : bank_q[15:0];
        unique case (req_size_q)
            2'b00:   load_ext = req_uns_q ? {24'b0, load_b} : {{24{load_b[7]}}, load_b};
            2'b01:   load_ext = req_uns_q ? {16'b0, load_h} : {{16{load_h[15]}}, load_h};
            default: load_ext = bank_q;
        endcase
        rdata_d = (acc_err || req_we_q) ? 32'b0 : load_ext;
    end

    // Narrow stores are replicated so the selected lanes see the right bytes wherever they sit.
    always_comb begin
        unique case (req_size_q)
            2'b00:   bank_d = {4{req_wdata_q[7:0]}};
            2'b01:   bank_d = {2{req_wdata_q[15:0]}};
            default: bank_d = req_wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bank_we    = 1'b0;
        bank_sel   = 4'b0000;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                if (!acc_err) begin
                    bank_sel = lane_mask;
                    // A reset landing on this edge must not leave a partial write behind.
                    bank_we  = req_we_q && rst_n;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign bank_addr  = req_addr_q[BANK_AW+1:2];
endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Bench for mem_lane_ctrl: behavioural banks plus a byte-array reference model of the memory.
module tb_mem_lane_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  bank_addr;
    logic [31:0] bank_d, bank_q;
    logic        bank_we;
    logic [3:0]  bank_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        err;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        acc_we;
        logic [3:0]  acc_sel;
        logic [9:0]  acc_addr;
        logic [31:0] acc_d;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        post_idle;
    } obs_t;

    mem_lane_ctrl #(.BANK_AW(10), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bank_addr(bank_addr), .bank_d(bank_d), .bank_we(bank_we),
        .bank_sel(bank_sel), .bank_q(bank_q)
    );

    always #5 clk = ~clk;

    logic [7:0] bank_mem [4][1024];
    logic [7:0] ref_mem [4096];
    logic       mem_fill = 1'b1;

    function automatic logic [7:0] pat(int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int a = 0; a < 4096; a++) bank_mem[a % 4][a / 4] <= pat(a);
        end else begin
            for (int k = 0; k < 4; k++)
                if (bank_we && bank_sel[k]) bank_mem[k][bank_addr] <= bank_d[8*k +: 8];
        end
    end

    always_comb begin
        bank_q = '0;
        for (int k = 0; k < 4; k++) bank_q[8*k +: 8] = bank_mem[k][bank_addr];
    end

    // Reference: memory as a flat byte array, accesses as little-endian byte runs.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, output exp_t e);
        int n = 1 << size;
        longint v = 0;
        e = '0;
        e.err = (size == 2'b11) || ((addr % n) != 0) || (addr >= 32'd4096);
        for (int k = 0; k < 4; k++) e.d[8*k +: 8] = wdata[8*(k % n) +: 8];
        if (!e.err) begin
            for (int i = 0; i < n; i++) e.sel[(addr % 4) + i] = 1'b1;
            e.we = we;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(addr) + i]) << (8 * i));
                if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
                e.rdata = v[31:0];
            end
        end
    endtask

    // Drives one request from the #1-after-edge point and records what the DUT shows.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, output obs_t o);
        bit acc = 0;
        int waitc = 0;
        o = '0;
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        while (!acc && waitc < 10) begin
            acc = req_ready;
            @(posedge clk); #1;
            waitc++;
        end
        req_valid = 1'b0;
        if (acc) begin
            o.acc_we = bank_we; o.acc_sel = bank_sel; o.acc_addr = bank_addr; o.acc_d = bank_d;
            @(posedge clk); #1;
            o.rv = resp_valid; o.err = resp_err; o.rdata = resp_rdata;
            @(posedge clk); #1;
            o.post_idle = !resp_valid && !bank_we && (bank_sel == 4'b0) && req_ready;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
        for (int a = 0; a < 4096; a++) ref_mem[a] = pat(a);
        repeat (3) @(posedge clk);
        #1;
        mem_fill = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'b0 ||
            bank_we !== 1'b0 || bank_sel !== 4'b0 || bank_addr !== 10'b0 || bank_d !== 32'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b rv=%b err=%b rdata=%h we=%b sel=%b addr=%h d=%h exp 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_err, resp_rdata, bank_we, bank_sel, bank_addr, bank_d);
        end
    endtask

    task automatic test_word;
        obs_t o; exp_t e;
        model(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, e);
        run_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, o);
        checks++;
        if (o.acc_addr !== 10'd4 || o.acc_sel !== 4'b1111 || o.acc_we !== 1'b1 || o.acc_d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_store_access addr=%0d sel=%b we=%b d=%h exp 4,1111,1,deadbeef",
                     o.acc_addr, o.acc_sel, o.acc_we, o.acc_d);
        end
        checks++;
        if (o.rv !== 1'b1 || o.err !== e.err || o.rdata !== 32'b0 || o.post_idle !== 1'b1) begin
            failures++;
            $display("FAIL word_store_resp rv=%b err=%b rdata=%h idle=%b exp 1,%b,0,1", o.rv, o.err, o.rdata, o.post_idle, e.err);
        end
        model(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, e);
        run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, o);
        checks++;
        if (o.rv !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'hDEADBEEF || o.acc_we !== 1'b0 || o.acc_sel !== e.sel) begin
            failures++;
            $display("FAIL word_load rv=%b err=%b rdata=%h we=%b sel=%b exp 1,0,deadbeef,0,%b",
                     o.rv, o.err, o.rdata, o.acc_we, o.acc_sel, e.sel);
        end
    endtask

    task automatic test_half;
        obs_t o; exp_t e;
        logic [31:0] addrs [3] = '{32'h12, 32'h12, 32'h10};
        logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] want  [3] = '{32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFBEEF};
        for (int i = 0; i < 3; i++) begin
            model(1'b0, addrs[i], 2'b01, unss[i], 32'h0, e);
            run_req(1'b0, addrs[i], 2'b01, unss[i], 32'h0, o);
            checks++;
            if (o.rv !== 1'b1 || o.err !== 1'b0 || o.rdata !== want[i] || o.rdata !== e.rdata || o.acc_sel !== e.sel) begin
                failures++;
                $display("FAIL half_load_%0d rdata=%h err=%b sel=%b exp %h,0,%b", i, o.rdata, o.err, o.acc_sel, want[i], e.sel);
            end
        end
    endtask

    task automatic test_byte;
        obs_t o; exp_t e;
        model(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, e);
        run_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, o);
        checks++;
        if (o.acc_sel !== 4'b1000 || o.acc_we !== 1'b1 || o.acc_d !== 32'h80808080 || o.rv !== 1'b1 || o.err !== 1'b0) begin
            failures++;
            $display("FAIL byte_store sel=%b we=%b d=%h rv=%b err=%b exp 1000,1,80808080,1,0",
                     o.acc_sel, o.acc_we, o.acc_d, o.rv, o.err);
        end
        model(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, e);
        run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, o);
        checks++;
        if (o.rdata !== 32'h80ADBEEF || o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL byte_store_neighbours rdata=%h exp 80adbeef", o.rdata);
        end
        run_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hFFFFFF80 || o.err !== 1'b0) begin
            failures++;
            $display("FAIL byte_load_signed rdata=%h err=%b exp ffffff80,0", o.rdata, o.err);
        end
        run_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, o);
        checks++;
        if (o.rdata !== 32'h00000080 || o.err !== 1'b0) begin
            failures++;
            $display("FAIL byte_load_unsigned rdata=%h err=%b exp 00000080,0", o.rdata, o.err);
        end
    endtask

    task automatic test_errors;
        obs_t o; exp_t e;
        logic        wes   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] addrs [4] = '{32'h11, 32'h3, 32'h14, 32'h1000};
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            model(wes[i], addrs[i], sizes[i], 1'b0, $urandom(), e);
            run_req(wes[i], addrs[i], sizes[i], 1'b0, $urandom(), o);
            checks++;
            if (o.rv !== 1'b1 || o.err !== 1'b1 || e.err !== 1'b1 || o.rdata !== 32'b0 ||
                o.acc_we !== 1'b0 || o.acc_sel !== 4'b0) begin
                failures++;
                $display("FAIL error_case_%0d rv=%b err=%b rdata=%h we=%b sel=%b exp 1,1,0,0,0",
                         i, o.rv, o.err, o.rdata, o.acc_we, o.acc_sel);
            end
        end
        model(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, e);
        run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, o);
        checks++;
        if (o.rdata !== e.rdata || o.err !== 1'b0) begin
            failures++;
            $display("FAIL error_mem_unchanged rdata=%h exp %h", o.rdata, e.rdata);
        end
    endtask

    task automatic test_back_to_back;
        exp_t q[$];
        exp_t e;
        int last = -10;
        int acc_n = 0, resp_n = 0;
        bit exp_rdy, exp_rv;
        for (int j = 0; j < 70; j++) begin
            if (j == 0 || j == last) begin
                req_we = 1'($urandom());
                req_size = 2'($urandom_range(0, 3));
                req_unsigned = 1'($urandom());
                req_wdata = $urandom();
                req_addr = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h1000) : 32'($urandom_range(0, 255));
            end
            req_valid = (j < 60);
            exp_rdy = (j - last) >= 2;
            exp_rv  = (j - last) == 1;
            checks++;
            if (req_ready !== exp_rdy || resp_valid !== exp_rv) begin
                failures++;
                $display("FAIL b2b_handshake_c%0d ready=%b rv=%b exp %b,%b", j, req_ready, resp_valid, exp_rdy, exp_rv);
            end
            if (resp_valid === 1'b1) begin
                resp_n++;
                e = (q.size() > 0) ? q.pop_front() : exp_t'('1);
                checks++;
                if (resp_err !== e.err || resp_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL b2b_resp_c%0d err=%b rdata=%h exp %b,%h", j, resp_err, resp_rdata, e.err, e.rdata);
                end
            end
            if (req_valid && req_ready === 1'b1) begin
                model(req_we, req_addr, req_size, req_unsigned, req_wdata, e);
                q.push_back(e);
                acc_n++;
                last = j + 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        checks++;
        if (acc_n !== resp_n || q.size() != 0 || acc_n < 15) begin
            failures++;
            $display("FAIL b2b_counts accepts=%0d responses=%0d pending=%0d exp equal, 0 pending, >=15", acc_n, resp_n, q.size());
        end
    endtask

    task automatic test_reset_mid;
        obs_t o; exp_t e;
        bit acc = 0;
        int waitc = 0;
        model(1'b1, 32'h20, 2'b10, 1'b0, 32'hA5C3_0F96, e);
        run_req(1'b1, 32'h20, 2'b10, 1'b0, 32'hA5C3_0F96, o);
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        while (!acc && waitc < 10) begin
            acc = req_ready;
            @(posedge clk); #1;
            waitc++;
        end
        req_valid = 1'b0;
        checks++;
        if (!acc || bank_we !== 1'b1 || bank_sel !== 4'b1111) begin
            failures++;
            $display("FAIL rstmid_access acc=%0d we=%b sel=%b exp 1,1,1111", acc, bank_we, bank_sel);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'b0 ||
            bank_we !== 1'b0 || bank_sel !== 4'b0 || bank_addr !== 10'b0 || bank_d !== 32'b0) begin
            failures++;
            $display("FAIL rstmid_outputs ready=%b rv=%b err=%b rdata=%h we=%b sel=%b addr=%h d=%h exp 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_err, resp_rdata, bank_we, bank_sel, bank_addr, bank_d);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_resp rv=%b exp 0", resp_valid);
        end
        model(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, e);
        run_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, o);
        checks++;
        if (o.rdata !== 32'hA5C3_0F96 || o.rdata !== e.rdata || o.rv !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_mem_kept rdata=%h rv=%b exp a5c30f96,1", o.rdata, o.rv);
        end
    endtask

    task automatic test_mem_image;
        int bad = 0;
        for (int a = 0; a < 4096; a++)
            if (bank_mem[a % 4][a / 4] !== ref_mem[a]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mem_image mismatching_bytes=%0d exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_mem_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
